// File: rtl/draw_obstacles.sv
// draw_obstacles: overlays two bouncing hazard bars on the VGA stream
// and pulses player_hit when the mouse cursor touches a bar.
//
// Ports:
//   pclk, rst            - pixel clock, synchronous active-high reset
//   hcount_in..vblnk_in  - upstream timing
//   rgb_in               - upstream pixel colour
//   game_on              - game mode active
//   xpos, ypos           - mouse cursor position
//   hcount_out..vblnk_out- timing delayed by one cycle
//   rgb_out              - pixel colour with bars overlaid
//   player_hit           - one-cycle hit pulse
module draw_obstacles #(
    parameter int TOP_V_LINE      = 317,
    parameter int BOTTOM_V_LINE   = 617,
    parameter int LEFT_H_LINE     = 361,
    parameter int RIGHT_H_LINE    = 661,
    parameter int BAR_W           = 8,
    parameter int SPEED           = 2,
    parameter int COOLDOWN_FRAMES = 60,
    parameter logic [11:0] BAR_COLOR = 12'hF00
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic [11:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        game_on,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [11:0] hcount_out,
    output logic [11:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic        player_hit
);

    localparam logic [12:0] LP_Y_MIN = 13'(TOP_V_LINE);
    localparam logic [12:0] LP_Y_MAX = 13'(BOTTOM_V_LINE - BAR_W + 1);
    localparam logic [12:0] LP_X_MIN = 13'(LEFT_H_LINE);
    localparam logic [12:0] LP_X_MAX = 13'(RIGHT_H_LINE - BAR_W + 1);
    localparam logic [12:0] LP_SPD   = 13'(SPEED);
    localparam logic [12:0] LP_BW1   = 13'(BAR_W - 1);
    localparam logic [12:0] LP_TOP   = 13'(TOP_V_LINE);
    localparam logic [12:0] LP_BOT   = 13'(BOTTOM_V_LINE);
    localparam logic [12:0] LP_LEFT  = 13'(LEFT_H_LINE);
    localparam logic [12:0] LP_RIGHT = 13'(RIGHT_H_LINE);
    localparam logic [15:0] LP_CD    = 16'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_COOL
    } state_t;

    state_t      r_state;
    logic        r_vblnk_d;
    logic [11:0] r_bar_y;
    logic [11:0] r_bar_x;
    logic        r_up_y;
    logic        r_left_x;
    logic [15:0] r_cnt;

    logic        w_tick;
    logic [11:0] w_y_nx;
    logic [11:0] w_x_nx;
    logic        w_up_y_nx;
    logic        w_left_x_nx;
    logic        w_pix_in_bar;
    logic        w_hit;

    // Point inside either bar; all math widened to avoid wrap.
    function automatic logic in_bars(
        input logic [11:0] px,
        input logic [11:0] py,
        input logic [11:0] by,
        input logic [11:0] bx
    );
        logic [12:0] x, y, y0, x0;
        logic hb, vb;
        x  = {1'b0, px};
        y  = {1'b0, py};
        y0 = {1'b0, by};
        x0 = {1'b0, bx};
        hb = (y >= y0) && (y <= y0 + LP_BW1) &&
             (x >= LP_LEFT) && (x <= LP_RIGHT);
        vb = (x >= x0) && (x <= x0 + LP_BW1) &&
             (y >= LP_TOP) && (y <= LP_BOT);
        return hb | vb;
    endfunction

    assign w_tick       = vblnk_in & ~r_vblnk_d;
    assign w_pix_in_bar = in_bars(hcount_in, vcount_in, r_bar_y, r_bar_x);
    assign w_hit        = in_bars(xpos, ypos, r_bar_y, r_bar_x);

    // Next bar positions for a movement tick, clamped at the walls.
    always_comb begin
        w_y_nx      = r_bar_y;
        w_up_y_nx   = r_up_y;
        w_x_nx      = r_bar_x;
        w_left_x_nx = r_left_x;
        if (!r_up_y) begin
            if ({1'b0, r_bar_y} + LP_SPD > LP_Y_MAX) begin
                w_y_nx    = LP_Y_MAX[11:0];
                w_up_y_nx = 1'b1;
            end else begin
                w_y_nx = r_bar_y + LP_SPD[11:0];
            end
        end else begin
            if ({1'b0, r_bar_y} < LP_Y_MIN + LP_SPD) begin
                w_y_nx    = LP_Y_MIN[11:0];
                w_up_y_nx = 1'b0;
            end else begin
                w_y_nx = r_bar_y - LP_SPD[11:0];
            end
        end
        if (!r_left_x) begin
            if ({1'b0, r_bar_x} + LP_SPD > LP_X_MAX) begin
                w_x_nx      = LP_X_MAX[11:0];
                w_left_x_nx = 1'b1;
            end else begin
                w_x_nx = r_bar_x + LP_SPD[11:0];
            end
        end else begin
            if ({1'b0, r_bar_x} < LP_X_MIN + LP_SPD) begin
                w_x_nx      = LP_X_MIN[11:0];
                w_left_x_nx = 1'b0;
            end else begin
                w_x_nx = r_bar_x - LP_SPD[11:0];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_vblnk_d  <= 1'b0;
            r_bar_y    <= LP_Y_MIN[11:0];
            r_bar_x    <= LP_X_MIN[11:0];
            r_up_y     <= 1'b0;
            r_left_x   <= 1'b0;
            r_cnt      <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
            player_hit <= 1'b0;
        end else begin
            r_vblnk_d  <= vblnk_in;
            hcount_out <= hcount_in;
            vcount_out <= vcount_in;
            hsync_out  <= hsync_in;
            vsync_out  <= vsync_in;
            hblnk_out  <= hblnk_in;
            vblnk_out  <= vblnk_in;
            if (!hblnk_in && !vblnk_in &&
                r_state != S_IDLE && w_pix_in_bar)
                rgb_out <= BAR_COLOR;
            else
                rgb_out <= rgb_in;
            player_hit <= 1'b0;
            if (!game_on) begin
                r_state  <= S_IDLE;
                r_bar_y  <= LP_Y_MIN[11:0];
                r_bar_x  <= LP_X_MIN[11:0];
                r_up_y   <= 1'b0;
                r_left_x <= 1'b0;
                r_cnt    <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE: r_state <= S_RUN;
                    S_RUN: if (w_tick) begin
                        r_bar_y  <= w_y_nx;
                        r_bar_x  <= w_x_nx;
                        r_up_y   <= w_up_y_nx;
                        r_left_x <= w_left_x_nx;
                        if (w_hit) begin
                            player_hit <= 1'b1;
                            r_state    <= S_COOL;
                            r_cnt      <= LP_CD;
                        end
                    end
                    S_COOL: if (w_tick) begin
                        r_bar_y  <= w_y_nx;
                        r_bar_x  <= w_x_nx;
                        r_up_y   <= w_up_y_nx;
                        r_left_x <= w_left_x_nx;
                        r_cnt    <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1)
                            r_state <= S_RUN;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_draw_obstacles.sv
// tb_draw_obstacles: directed self-checking bench for draw_obstacles.
// Bar positions are inferred from rendered pixels and hit pulses.
module tb_draw_obstacles;

    logic        pclk = 1'b0;
    logic        rst;
    logic [11:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic        game_on;
    logic [11:0] xpos, ypos;
    logic [11:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic        player_hit;

    int n_checks = 0;
    int n_err    = 0;

    always #5 pclk = ~pclk;

    draw_obstacles dut (
        .pclk       (pclk),
        .rst        (rst),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .hblnk_in   (hblnk_in),
        .vblnk_in   (vblnk_in),
        .rgb_in     (rgb_in),
        .game_on    (game_on),
        .xpos       (xpos),
        .ypos       (ypos),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .player_hit (player_hit)
    );

    task automatic check(input string tag, input logic [11:0] obs,
                         input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // One frame tick; p1/p2 are player_hit in the two cycles after it.
    task automatic tick(output logic p1, output logic p2);
        vblnk_in = 1'b1;
        step();
        p1 = player_hit;
        vblnk_in = 1'b0;
        step();
        p2 = player_hit;
    endtask

    task automatic ticks(input int n);
        logic a, b;
        for (int i = 0; i < n; i++) tick(a, b);
    endtask

    task automatic probe(input string tag, input logic [11:0] h,
                         input logic [11:0] v, input logic hb,
                         input logic [11:0] exp_bar);
        hcount_in = h;
        vcount_in = v;
        hblnk_in  = hb;
        rgb_in    = 12'h2A5;
        step();
        check(tag, rgb_out, exp_bar ? 12'hF00 : 12'h2A5);
        hblnk_in = 1'b0;
    endtask

    logic p1, p2;

    initial begin
        rst       = 1'b1;
        hcount_in = 12'd5;
        vcount_in = 12'd7;
        hsync_in  = 1'b1;
        vsync_in  = 1'b1;
        hblnk_in  = 1'b1;
        vblnk_in  = 1'b0;
        rgb_in    = 12'hABC;
        game_on   = 1'b0;
        xpos      = 12'd0;
        ypos      = 12'd0;
        repeat (3) step();
        check("rst_hcount", hcount_out, 12'd0);
        check("rst_vcount", vcount_out, 12'd0);
        check("rst_sync", {10'd0, hsync_out, vsync_out}, 12'd0);
        check("rst_blnk", {10'd0, hblnk_out, vblnk_out}, 12'd0);
        check("rst_rgb", rgb_out, 12'h000);
        check("rst_hit", {11'd0, player_hit}, 12'd0);

        // Idle passthrough with 1-cycle latency.
        rst       = 1'b0;
        hblnk_in  = 1'b0;
        hsync_in  = 1'b0;
        hcount_in = 12'd400;
        vcount_in = 12'd317;
        rgb_in    = 12'h123;
        step();
        check("idle_rgb0", rgb_out, 12'h123);
        check("idle_hcnt", hcount_out, 12'd400);
        check("idle_vcnt", vcount_out, 12'd317);
        check("idle_hsync", {11'd0, hsync_out}, 12'd0);
        check("idle_vsync", {11'd0, vsync_out}, 12'd1);
        rgb_in = 12'h456;
        step();
        check("idle_rgb1", rgb_out, 12'h456);

        // First hit on the parked h-bar.
        game_on = 1'b1;
        xpos    = 12'd500;
        ypos    = 12'd319;
        step();
        tick(p1, p2);
        check("hit_pulse", {11'd0, p1}, 12'd1);
        check("hit_width", {11'd0, p2}, 12'd0);

        // Cooldown: cursor follows the h-bar, no pulse for 60 ticks.
        for (int k = 1; k <= 60; k++) begin
            ypos = 12'(317 + 2 * k);
            tick(p1, p2);
            check($sformatf("cool_%0d", k), {10'd0, p1, p2}, 12'd0);
        end

        // Tick 61: cursor on both bars gives a single pulse.
        xpos = 12'd485;
        ypos = 12'd440;
        tick(p1, p2);
        check("rehit_pulse", {11'd0, p1}, 12'd1);
        check("both_single", {11'd0, p2}, 12'd0);

        xpos = 12'd500;
        ypos = 12'd441;
        tick(p1, p2);
        check("cool_again", {10'd0, p1, p2}, 12'd0);

        // Game off mid-cooldown.
        game_on = 1'b0;
        step();
        check("off_hit", {11'd0, player_hit}, 12'd0);
        probe("off_nobar", 12'd500, 12'd317, 1'b0, 1'b0);
        probe("off_novbar", 12'd361, 12'd500, 1'b0, 1'b0);

        // Re-enable: bars must be re-parked at (361,317).
        game_on = 1'b1;
        xpos    = 12'd0;
        ypos    = 12'd0;
        step();
        probe("park_h_top", 12'd500, 12'd317, 1'b0, 1'b1);
        probe("park_h_bot", 12'd500, 12'd324, 1'b0, 1'b1);
        probe("park_h_out", 12'd500, 12'd325, 1'b0, 1'b0);
        probe("park_v_l", 12'd361, 12'd500, 1'b0, 1'b1);
        probe("park_v_r", 12'd368, 12'd500, 1'b0, 1'b1);
        probe("park_v_out", 12'd369, 12'd500, 1'b0, 1'b0);

        // Movement: 3 ticks -> bar_y 323, bar_x 367.
        ticks(3);
        probe("mv_h_in", 12'd400, 12'd323, 1'b0, 1'b1);
        probe("mv_h_out", 12'd400, 12'd340, 1'b0, 1'b0);
        probe("mv_h_above", 12'd400, 12'd322, 1'b0, 1'b0);
        probe("mv_v_in", 12'd367, 12'd340, 1'b0, 1'b1);
        probe("mv_v_left", 12'd366, 12'd340, 1'b0, 1'b0);
        probe("blank_h", 12'd400, 12'd323, 1'b1, 1'b0);

        // Bounce: 146 ticks total -> 609/653.
        ticks(143);
        probe("b609_top", 12'd500, 12'd609, 1'b0, 1'b1);
        probe("b609_above", 12'd500, 12'd608, 1'b0, 1'b0);
        probe("b609_bot", 12'd500, 12'd617, 1'b0, 1'b0);
        probe("bx653", 12'd653, 12'd400, 1'b0, 1'b1);
        ticks(1);
        probe("b610_top", 12'd500, 12'd610, 1'b0, 1'b1);
        probe("b610_above", 12'd500, 12'd609, 1'b0, 1'b0);
        probe("b610_bot", 12'd500, 12'd617, 1'b0, 1'b1);
        probe("bx654", 12'd654, 12'd400, 1'b0, 1'b1);
        probe("bx654_l", 12'd653, 12'd400, 1'b0, 1'b0);
        probe("bx654_r", 12'd661, 12'd400, 1'b0, 1'b1);
        ticks(1);
        probe("b608_top", 12'd500, 12'd608, 1'b0, 1'b1);
        probe("b608_out", 12'd500, 12'd616, 1'b0, 1'b0);
        ticks(1);
        probe("b606_top", 12'd500, 12'd606, 1'b0, 1'b1);
        probe("b606_out", 12'd500, 12'd614, 1'b0, 1'b0);
        probe("bx652", 12'd652, 12'd400, 1'b0, 1'b1);
        probe("bx652_out", 12'd660, 12'd400, 1'b0, 1'b0);

        // Hit, then reset mid-cooldown.
        xpos = 12'd500;
        ypos = 12'd606;
        tick(p1, p2);
        check("hit606", {11'd0, p1}, 12'd1);
        rst = 1'b1;
        step();
        check("rstc_hit", {11'd0, player_hit}, 12'd0);
        check("rstc_rgb", rgb_out, 12'h000);
        rst  = 1'b0;
        ypos = 12'd318;
        step();
        tick(p1, p2);
        check("post_rst_hit", {11'd0, p1}, 12'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
